pht_write_scheduler: RTL and testbench

PHT_WRITE_SCHEDULER -- requirements
Module: pht_write_scheduler

---
 rtl/pht_write_scheduler_pkg.sv | 28 ++
 rtl/pht_write_scheduler_queue_pointer.sv | 37 +++
 rtl/pht_write_scheduler.sv | 179 +++++++++++++++++
 tb/tb_pht_write_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pht_write_scheduler_pkg.sv
// Shared types for the PHT write scheduler: index/counter types, the
// deferred-queue entry and the bank-select helper.
package pht_write_scheduler_pkg;

  localparam int PHT_ENTRY_NUM      = 2048;
  localparam int PHT_ENTRY_BIT_SIZE = 2;
  localparam int PHT_INDEX_BIT      = $clog2(PHT_ENTRY_NUM);

  typedef logic [PHT_INDEX_BIT-1:0]      pht_index_t;
  typedef logic [PHT_ENTRY_BIT_SIZE-1:0] pht_entry_t;

  // One deferred write: RAM address and counter value.
  typedef struct packed {
    pht_index_t wa;
    pht_entry_t wv;
  } pht_qentry_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pht_state_t;

  // Bank holding a PHT index: index mod bank count.
  function automatic int unsigned bank_of(input pht_index_t idx, input int unsigned bank_num);
    return 32'(idx) % bank_num;
  endfunction

endpackage

// File: rtl/pht_write_scheduler_queue_pointer.sv
// Head/tail pointers of the deferred-write ring. An extra wrap bit on each
// pointer separates full from empty when the low bits are equal.
module QueuePointer #(
  parameter int QUEUE_SIZE = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(QUEUE_SIZE)-1:0] headPtr,
  output logic [$clog2(QUEUE_SIZE)-1:0] tailPtr
);

  localparam int PW = $clog2(QUEUE_SIZE);

  logic [PW:0] head_q;
  logic [PW:0] tail_q;

  // Advance each pointer independently; a push+pop pair keeps occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  assign headPtr = head_q[PW-1:0];
  assign tailPtr = tail_q[PW-1:0];
  assign empty   = (head_q == tail_q);
  assign full    = (head_q[PW] != tail_q[PW]) && (head_q[PW-1:0] == tail_q[PW-1:0]);

endmodule

// File: rtl/pht_write_scheduler.sv
// PHT write scheduler: sweeps the table with INIT_VALUE after reset, then
// forwards requester writes to the RAM ports with zero latency. A request
// that collides on a bank with a lower-numbered write is deferred into a
// small in-order queue and replayed on a free, non-conflicting port.
// Optional drop statistics: define PHT_WRITE_SCHEDULER_STAT_EN.
module pht_write_scheduler
  import pht_write_scheduler_pkg::*;
#(
  parameter int WRITE_NUM      = 2,
  parameter int ENTRY_NUM      = PHT_ENTRY_NUM,
  parameter int BANK_NUM       = 2,
  parameter int ENTRY_BIT_SIZE = PHT_ENTRY_BIT_SIZE,
  parameter int QUEUE_SIZE     = 4,
  parameter int INIT_VALUE     = 2
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic [WRITE_NUM-1:0]                         reqValid,
  input  logic [WRITE_NUM-1:0][$clog2(ENTRY_NUM)-1:0]  reqAddr,
  input  logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0]     reqValue,
  output logic [WRITE_NUM-1:0]                         we,
  output logic [WRITE_NUM-1:0][$clog2(ENTRY_NUM)-1:0]  wa,
  output logic [WRITE_NUM-1:0][ENTRY_BIT_SIZE-1:0]     wv,
  output logic                                         initBusy,
  output logic                                         queueFull
`ifdef PHT_WRITE_SCHEDULER_STAT_EN
  ,
  output logic [31:0]                                  dropCount
`endif
);

  localparam int AW = $clog2(ENTRY_NUM);
  localparam int EW = ENTRY_BIT_SIZE;
  localparam int IW = $clog2(WRITE_NUM);
  localparam int PW = $clog2(QUEUE_SIZE);

  pht_state_t  state;
  logic [AW-1:0] init_index;
  logic [AW-1:0] init_next;
  logic          run;

  logic [WRITE_NUM-1:0] pass;
  logic [WRITE_NUM-1:0] conflict;
  logic                 any_conf;
  logic [IW-1:0]        conf_idx;
  logic                 head_blocked;
  logic                 port_free;
  logic [IW-1:0]        pop_port;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [PW-1:0]        head_ptr;
  logic [PW-1:0]        tail_ptr;

  pht_qentry_t qmem [QUEUE_SIZE];
  pht_qentry_t head;
  pht_qentry_t qentry;

  assign run       = (state == ST_RUN);
  assign init_next = init_index + AW'(WRITE_NUM);
  assign head      = qmem[head_ptr];
  assign queueFull = full;

  QueuePointer #(.QUEUE_SIZE(QUEUE_SIZE)) u_qptr (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .full    (full),
    .empty   (empty),
    .headPtr (head_ptr),
    .tailPtr (tail_ptr)
  );

  // INIT sweeps WRITE_NUM entries per cycle; leave for RUN when the index wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_INIT;
      init_index <= '0;
      initBusy   <= 1'b1;
    end else if (state == ST_INIT) begin
      init_index <= init_next;
      if (init_next == '0) begin
        state    <= ST_RUN;
        initBusy <= 1'b0;
      end
    end
  end

  // Arbitration: pass non-colliding requests, pick the first collider for the
  // queue, and find a port where the queue head can go without a bank clash.
  always_comb begin
    pass         = '0;
    conflict     = '0;
    any_conf     = 1'b0;
    conf_idx     = '0;
    head_blocked = 1'b0;
    port_free    = 1'b0;
    pop_port     = '0;
    for (int i = 0; i < WRITE_NUM; i++) begin
      pass[i] = reqValid[i];
      for (int j = 0; j < i; j++)
        if (pass[j] && bank_of(reqAddr[j], BANK_NUM) == bank_of(reqAddr[i], BANK_NUM))
          pass[i] = 1'b0;
      conflict[i] = reqValid[i] & ~pass[i];
      if (conflict[i] && !any_conf) begin
        any_conf = 1'b1;
        conf_idx = IW'(i);
      end
    end
    for (int i = 0; i < WRITE_NUM; i++) begin
      if (pass[i] && bank_of(reqAddr[i], BANK_NUM) == bank_of(head.wa, BANK_NUM))
        head_blocked = 1'b1;
      if (!pass[i] && !port_free) begin
        port_free = 1'b1;
        pop_port  = IW'(i);
      end
    end
    pop    = run && !empty && port_free && !head_blocked;
    push   = run && any_conf && (!full || pop);
    qentry = '{wa: reqAddr[conf_idx], wv: reqValue[conf_idx]};
  end

  // Queue storage; only the slot at the tail is written on a push.
  always_ff @(posedge clk) begin
    if (push) qmem[tail_ptr] <= qentry;
  end

  // RAM port drive: init pattern, or direct writes plus one replayed entry.
  always_comb begin
    we = '0;
    wa = '0;
    wv = '0;
    if (!rst) begin
      if (state == ST_INIT) begin
        for (int i = 0; i < WRITE_NUM; i++) begin
          we[i] = 1'b1;
          wa[i] = init_index + AW'(i);
          wv[i] = EW'(INIT_VALUE);
        end
      end else begin
        we = pass;
        wa = reqAddr;
        wv = reqValue;
        if (pop) begin
          we[pop_port] = 1'b1;
          wa[pop_port] = head.wa;
          wv[pop_port] = head.wv;
        end
      end
    end
  end

`ifdef PHT_WRITE_SCHEDULER_STAT_EN
  logic [31:0] drop_n;

  // Requests lost this cycle: every collider except the one that was queued.
  always_comb begin
    drop_n = '0;
    for (int i = 0; i < WRITE_NUM; i++)
      drop_n = drop_n + 32'(conflict[i]);
    if (push) drop_n = drop_n - 32'd1;
  end

  // Saturating drop counter, cleared and held during the init sweep.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      dropCount <= '0;
    else if (state == ST_INIT)
      dropCount <= '0;
    else if (dropCount > (32'hFFFF_FFFF - drop_n))
      dropCount <= 32'hFFFF_FFFF;
    else
      dropCount <= dropCount + drop_n;
  end
`endif

endmodule

// File: tb/tb_pht_write_scheduler.sv
// Directed bench for pht_write_scheduler (default parameters). Expected RAM
// writes are queued with the cycle they must appear in and matched against
// the ports at each negative edge.
module tb_pht_write_scheduler;

  logic                  clk;
  logic                  rst;
  logic [1:0]            reqValid;
  logic [1:0][10:0]      reqAddr;
  logic [1:0][1:0]       reqValue;
  logic [1:0]            we;
  logic [1:0][10:0]      wa;
  logic [1:0][1:0]       wv;
  logic                  initBusy;
  logic                  queueFull;
`ifdef PHT_WRITE_SCHEDULER_STAT_EN
  logic [31:0]           dropCount;
`endif

  pht_write_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .reqValid  (reqValid),
    .reqAddr   (reqAddr),
    .reqValue  (reqValue),
    .we        (we),
    .wa        (wa),
    .wv        (wv),
    .initBusy  (initBusy),
    .queueFull (queueFull)
`ifdef PHT_WRITE_SCHEDULER_STAT_EN
    ,
    .dropCount (dropCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int port;
    int addr;
    int val;
  } wr_t;

  wr_t sb[$];
  int  errors = 0;
  int  checks = 0;
  int  cyc = 0;
  int  init_cycles = 0;
  int  seen [2048];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack_wr(input int c, input int p, input int a, input int v);
    return {16'(c), 8'(p), 16'(a), 8'(v)};
  endfunction

  task automatic expect_wr(input int port, input int addr, input int val);
    wr_t e;
    e.cyc = cyc; e.port = port; e.addr = addr; e.val = val;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v0, input int a0, input int d0,
                       input logic v1, input int a1, input int d1);
    reqValid    = {v1, v0};
    reqAddr[0]  = 11'(a0);
    reqAddr[1]  = 11'(a1);
    reqValue[0] = 2'(d0);
    reqValue[1] = 2'(d1);
  endtask

  // Sample the ports mid-cycle, then step past the next rising edge.
  task automatic tick();
    wr_t e;
    @(negedge clk);
    if (rst) begin
      check("we_in_reset", 64'(we), 64'd0);
    end else if (initBusy) begin
      init_cycles++;
      check("init_we", 64'(we), 64'd3);
      for (int i = 0; i < 2; i++) begin
        if (we[i]) begin
          seen[wa[i]]++;
          check("init_wv", 64'(wv[i]), 64'd2);
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (we[i]) begin
          if (sb.size() == 0) begin
            check("unexpected_write", pack_wr(cyc, i, int'(wa[i]), int'(wv[i])), 64'd0);
          end else begin
            e = sb.pop_front();
            check("write", pack_wr(cyc, i, int'(wa[i]), int'(wv[i])),
                  pack_wr(e.cyc, e.port, e.addr, e.val));
          end
        end
      end
      if (sb.size() > 0) begin
        checks++;
        assert (sb[0].cyc > cyc) else begin
          errors++;
          $error("FAIL missing_write: cycle %0d nothing on port %0d, expected addr %0d val %0d",
                 cyc, sb[0].port, sb[0].addr, sb[0].val);
          void'(sb.pop_front());
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_init();
    int bad;
    bit done;
    for (int k = 0; k < 2048; k++) seen[k] = 0;
    init_cycles = 0;
    done = 1'b0;
    for (int n = 0; n < 1100 && !done; n++) begin
      tick();
      if (!initBusy) done = 1'b1;
    end
    check("init_cycles", 64'(init_cycles), 64'd1024);
    check("init_done", 64'(initBusy), 64'd0);
    bad = 0;
    for (int k = 0; k < 2048; k++) if (seen[k] != 1) bad++;
    check("init_coverage_bad", 64'(bad), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #1;
    check("rst_initBusy", 64'(initBusy), 64'd1);
    check("rst_queueFull", 64'(queueFull), 64'd0);
    tick();
    rst = 1'b0;
    run_init();

    // both banks differ: two direct writes in one cycle
    drive(1, 4, 1, 1, 7, 3); expect_wr(0, 4, 1); expect_wr(1, 7, 3); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    check("noconf_qfull", 64'(queueFull), 64'd0);

    // same bank: addr 6 deferred, replayed on port 0 in the idle cycle
    drive(1, 4, 2, 1, 6, 1); expect_wr(0, 4, 2); tick();
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 6, 1); tick();
    drive(0, 0, 0, 0, 0, 0); tick();

    // fill the queue with bank-0 colliders while bank 0 stays busy
    for (int k = 0; k < 5; k++) begin
      check("fill_qfull", 64'(queueFull), 64'(k == 4));
      drive(1, 8 * k, k % 4, 1, 8 * k + 2, (k + 1) % 4);
      expect_wr(0, 8 * k, k % 4);
      tick();
    end
    check("full_after5", 64'(queueFull), 64'd1);
`ifdef PHT_WRITE_SCHEDULER_STAT_EN
    check("dropCount_1", 64'(dropCount), 64'd1);
`endif
    // full queue: push and pop in the same cycle keeps it full
    drive(1, 33, 1, 1, 35, 2); expect_wr(0, 33, 1); expect_wr(1, 2, 1); tick();
    check("full_pushpop", 64'(queueFull), 64'd1);
`ifdef PHT_WRITE_SCHEDULER_STAT_EN
    check("dropCount_hold", 64'(dropCount), 64'd1);
`endif
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 10, 2); tick();
    check("drain_qfull", 64'(queueFull), 64'd0);
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 18, 3); tick();
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 26, 0); tick();
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 35, 2); tick();
    drive(0, 0, 0, 0, 0, 0); tick();

    // head on bank 0 held for three busy cycles, order preserved
    drive(1, 10, 1, 1, 12, 2); expect_wr(0, 10, 1); tick();
    drive(1, 20, 0, 1, 14, 3); expect_wr(0, 20, 0); tick();
    drive(1, 22, 1, 0, 0, 0);  expect_wr(0, 22, 1); tick();
    drive(1, 24, 2, 0, 0, 0);  expect_wr(0, 24, 2); tick();
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 12, 2); tick();
    drive(0, 0, 0, 0, 0, 0); expect_wr(0, 14, 3); tick();

    // head on bank 1 replayed on port 1 beside a bank-0 direct write
    drive(1, 1, 1, 1, 3, 2); expect_wr(0, 1, 1); tick();
    drive(1, 8, 0, 0, 0, 0); expect_wr(0, 8, 0); expect_wr(1, 3, 2); tick();
    drive(0, 0, 0, 0, 0, 0); tick();

    // three entries queued, then reset mid-run
    drive(1, 40, 1, 1, 46, 1); expect_wr(0, 40, 1); tick();
    drive(1, 42, 2, 1, 48, 2); expect_wr(0, 42, 2); tick();
    drive(1, 44, 3, 1, 50, 3); expect_wr(0, 44, 3); tick();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_we", 64'(we), 64'd0);
    check("midrst_initBusy", 64'(initBusy), 64'd1);
    check("midrst_queueFull", 64'(queueFull), 64'd0);
`ifdef PHT_WRITE_SCHEDULER_STAT_EN
    check("midrst_dropCount", 64'(dropCount), 64'd0);
`endif
    tick();
    rst = 1'b0;
    run_init();
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, 0, 0, 0, 0);
      tick();
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
